// File: rtl/vedicmult_pkg.sv
// Shared widths, types and helpers for the two-requester Vedic multiplier.
// Imported by the interface, the multiplier and the arbiter top.
package vedicmult_pkg;

    localparam int W_OP         = 16;
    localparam int W_PROD       = 32;
    localparam int MULT_LAT_DEF = 1;

    typedef logic [0:0] req_id_t;

    // One slot of the in-flight tracker: occupancy and owning requester.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } track_t;

    // 8x8 Urdhva-Tiryagbhyam step built from four 4x4 partial products:
    // vertical (hi*hi, lo*lo) and crosswise (hi*lo + lo*hi) terms.
    function automatic logic [15:0] vedic8(input logic [7:0] x,
                                           input logic [7:0] y);
        logic [7:0] hh, hl, lh, ll;
        logic [8:0] mid;
        hh  = {4'b0, x[7:4]} * {4'b0, y[7:4]};
        hl  = {4'b0, x[7:4]} * {4'b0, y[3:0]};
        lh  = {4'b0, x[3:0]} * {4'b0, y[7:4]};
        ll  = {4'b0, x[3:0]} * {4'b0, y[3:0]};
        mid = {1'b0, hl} + {1'b0, lh};
        return {hh, ll} + {3'b0, mid, 4'b0};
    endfunction

endpackage

// File: rtl/vedicmult_arbiter_if.sv
// Request/response bundle between two requesters and the arbiter.
// master: requester side (drives valid/operands); slave: arbiter side.
interface vedicmult_arbiter_if;
    import vedicmult_pkg::*;

    logic              req0_valid;
    logic [W_OP-1:0]   req0_a;
    logic [W_OP-1:0]   req0_b;
    logic              req0_ready;
    logic              req1_valid;
    logic [W_OP-1:0]   req1_a;
    logic [W_OP-1:0]   req1_b;
    logic              req1_ready;
    logic              rsp_valid;
    req_id_t           rsp_id;
    logic [W_PROD-1:0] rsp_prod;
    logic              busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_prod, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_prod, busy
    );

endinterface

// File: rtl/vedicmult_16bit.sv
// Pipelined 16x16 unsigned Vedic multiplier, MULT_LAT register stages.
// Ports: a, b operands; clk; reset (sync, active-high); out product.
module vedicmult_16bit
    import vedicmult_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF
) (
    input  logic [W_OP-1:0]   a,
    input  logic [W_OP-1:0]   b,
    input  logic              clk,
    input  logic              reset,
    output logic [W_PROD-1:0] out
);

    logic [15:0]       pp_hh, pp_hl, pp_lh, pp_ll;
    logic [16:0]       mid;
    logic [W_PROD-1:0] comb;
    logic [W_PROD-1:0] pipe [MULT_LAT];

    // Same vertical/crosswise split one level up, on 8-bit halves.
    always_comb begin
        pp_hh = vedic8(a[15:8], b[15:8]);
        pp_hl = vedic8(a[15:8], b[7:0]);
        pp_lh = vedic8(a[7:0],  b[15:8]);
        pp_ll = vedic8(a[7:0],  b[7:0]);
        mid   = {1'b0, pp_hl} + {1'b0, pp_lh};
        comb  = {pp_hh, pp_ll} + {7'b0, mid, 8'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MULT_LAT; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= comb;
            for (int i = 1; i < MULT_LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign out = pipe[MULT_LAT-1];

endmodule

// File: rtl/vedicmult_arbiter.sv
// Round-robin front end sharing one Vedic multiplier between two requesters.
// Ports: clk; reset (sync, active-high); bus (slave side of the bundle).
module vedicmult_arbiter
    import vedicmult_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    vedicmult_arbiter_if.slave   bus
);

    req_id_t                  rr;
    logic                     ready0, ready1;
    logic                     xfer;
    req_id_t                  xfer_id;
    logic [W_OP-1:0]          op_a, op_b;
    logic [W_PROD-1:0]        mult_out;
    track_t [MULT_LAT:0]      trk;
    logic                     busy_or;

    // Requester wins if it holds the turn or the other side is idle.
    always_comb begin
        ready0  = !reset && bus.req0_valid &&
                  (rr == 1'b0 || !bus.req1_valid);
        ready1  = !reset && bus.req1_valid &&
                  (rr == 1'b1 || !bus.req0_valid);
        xfer    = ready0 || ready1;
        xfer_id = req_id_t'(ready1);
    end

    // Operands are held between transfers so the multiplier stays quiet.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr   <= '0;
            op_a <= '0;
            op_b <= '0;
        end else if (xfer) begin
            rr   <= ~xfer_id;
            op_a <= ready1 ? bus.req1_a : bus.req0_a;
            op_b <= ready1 ? bus.req1_b : bus.req0_b;
        end
    end

    // Slot 0 lines up with the operand registers; slot MULT_LAT with out.
    always_ff @(posedge clk) begin
        if (reset) begin
            trk <= '0;
        end else begin
            trk[0] <= '{valid: xfer, id: xfer_id};
            for (int i = 1; i <= MULT_LAT; i++)
                trk[i] <= trk[i-1];
        end
    end

    always_comb begin
        busy_or = 1'b0;
        for (int i = 0; i <= MULT_LAT; i++)
            busy_or = busy_or | trk[i].valid;
    end

    vedicmult_16bit #(
        .MULT_LAT (MULT_LAT)
    ) u_mult (
        .a     (op_a),
        .b     (op_b),
        .clk   (clk),
        .reset (reset),
        .out   (mult_out)
    );

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = trk[MULT_LAT].valid;
    assign bus.rsp_id     = trk[MULT_LAT].valid ? trk[MULT_LAT].id : '0;
    assign bus.rsp_prod   = trk[MULT_LAT].valid ? mult_out : '0;
    assign bus.busy       = busy_or;

endmodule

// File: tb/tb_vedicmult_arbiter.sv
// Self-checking bench for vedicmult_arbiter against a queue-based model.
// Drives both requesters through the bus interface; samples at negedge.
module tb_vedicmult_arbiter;
    import vedicmult_pkg::*;

    localparam int LAT = MULT_LAT_DEF;

    typedef struct packed {
        logic        r0;
        logic        r1;
        logic        v;
        logic        id;
        logic [31:0] prod;
        logic        busy;
    } obs_t;

    typedef struct {
        int          due;
        logic        id;
        logic [31:0] prod;
    } pend_t;

    logic  clk = 1'b0;
    logic  reset;
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    logic  turn_m = 1'b0;
    pend_t sb[$];

    always #5 clk = ~clk;

    vedicmult_arbiter_if bus();

    vedicmult_arbiter #(
        .MULT_LAT (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic drive(input logic v0, input logic [15:0] a0,
                         input logic [15:0] b0, input logic v1,
                         input logic [15:0] a1, input logic [15:0] b1);
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
    endtask

    // Advance one cycle: sample DUT, derive expectation from the model,
    // then update the model with whatever the rules say is accepted.
    task automatic step(output obs_t o, output obs_t w);
        logic  g0, g1;
        pend_t p;
        @(negedge clk);
        o.r0   = bus.req0_ready;
        o.r1   = bus.req1_ready;
        o.v    = bus.rsp_valid;
        o.id   = bus.rsp_id;
        o.prod = bus.rsp_prod;
        o.busy = bus.busy;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!reset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                g0 = (turn_m == 1'b0);
                g1 = (turn_m == 1'b1);
            end else begin
                g0 = bus.req0_valid;
                g1 = bus.req1_valid;
            end
        end
        w      = '0;
        w.r0   = g0;
        w.r1   = g1;
        w.busy = (sb.size() != 0);
        if (sb.size() != 0 && sb[0].due == cyc) begin
            w.v    = 1'b1;
            w.id   = sb[0].id;
            w.prod = sb[0].prod;
            void'(sb.pop_front());
        end
        if (reset) begin
            sb.delete();
            turn_m = 1'b0;
        end else if (g0 || g1) begin
            p.due  = cyc + 1 + LAT;
            p.id   = g1;
            p.prod = g1 ? {16'b0, bus.req1_a} * {16'b0, bus.req1_b}
                        : {16'b0, bus.req0_a} * {16'b0, bus.req0_b};
            sb.push_back(p);
            turn_m = g1 ? 1'b0 : 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        obs_t o, w;
        reset = 1'b1;
        drive(1, 16'd3, 16'd4, 1, 16'd6, 16'd7);
        for (int i = 0; i < 3; i++) begin
            step(o, w);
            checks++;
            if (o !== w || o.r0 || o.r1 || o.v || o.busy) begin
                failures++;
                $display("FAIL reset[%0d] got=%h want=%h", i, o, w);
            end
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step(o, w);
        checks++;
        if (o !== w || o.v || o.busy || o.prod != 0 || o.id) begin
            failures++;
            $display("FAIL reset_after got=%h want=%h", o, w);
        end
    endtask

    task automatic test_single();
        obs_t o, w;
        int   acc, got_at;
        logic [31:0] got_p;
        got_at = -1;
        got_p  = '0;
        drive(1, 16'd5, 16'd8, 0, 0, 0);
        acc = cyc;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) drive(0, 0, 0, 0, 0, 0);
            step(o, w);
            checks++;
            if (o !== w) begin
                failures++;
                $display("FAIL single[%0d] got=%h want=%h", i, o, w);
            end
            if (o.v) begin
                got_at = cyc - 1;
                got_p  = o.prod;
            end
        end
        checks++;
        if (got_at != acc + 2 || got_p != 32'd40) begin
            failures++;
            $display("FAIL single_rsp got cyc=%0d p=%0d want cyc=%0d p=40",
                     got_at, got_p, acc + 2);
        end
    endtask

    task automatic test_contention();
        obs_t o, w;
        logic [31:0] rp[$];
        logic        ri[$];
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step(o, w);
        reset = 1'b0;
        drive(1, 16'd25, 16'd27, 1, 16'd19, 16'd20);
        for (int i = 0; i < 7; i++) begin
            if (i == 4) drive(0, 0, 0, 0, 0, 0);
            step(o, w);
            checks++;
            if (o !== w) begin
                failures++;
                $display("FAIL contend[%0d] got=%h want=%h", i, o, w);
            end
            if (i < 4) begin
                checks++;
                if (o.r0 !== (i % 2 == 0) || o.r1 !== (i % 2 == 1)) begin
                    failures++;
                    $display("FAIL grant[%0d] got r0=%b r1=%b", i, o.r0, o.r1);
                end
            end
            if (o.v) begin
                rp.push_back(o.prod);
                ri.push_back(o.id);
            end
        end
        checks++;
        if (rp.size() != 4) begin
            failures++;
            $display("FAIL contend_cnt got=%0d want=4", rp.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rp[i] != ((i % 2) ? 32'd380 : 32'd675) || ri[i] !== i[0]) begin
                    failures++;
                    $display("FAIL contend_rsp[%0d] got p=%0d id=%b", i, rp[i], ri[i]);
                end
            end
        end
    endtask

    task automatic test_corners();
        obs_t o, w;
        logic [31:0] rp[$];
        drive(1, 16'hFFFF, 16'hFFFF, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) drive(1, 16'h0000, 16'h1234, 0, 0, 0);
            if (i == 2) drive(0, 0, 0, 0, 0, 0);
            step(o, w);
            checks++;
            if (o !== w) begin
                failures++;
                $display("FAIL corner[%0d] got=%h want=%h", i, o, w);
            end
            if (o.v) rp.push_back(o.prod);
        end
        checks++;
        if (rp.size() != 2 || rp[0] != 32'hFFFE0001 || rp[1] != 32'd0) begin
            failures++;
            $display("FAIL corner_vals got n=%0d p0=%h want p0=fffe0001 p1=0",
                     rp.size(), (rp.size() > 0) ? rp[0] : 32'hx);
        end
    endtask

    task automatic test_reset_midflight();
        obs_t o, w;
        logic seen;
        seen = 1'b0;
        drive(1, 16'd73, 16'd20, 0, 0, 0);
        step(o, w);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step(o, w);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(o, w);
            checks++;
            if (o !== w || o.busy) begin
                failures++;
                $display("FAIL midflight[%0d] got=%h want=%h", i, o, w);
            end
            if (o.v || o.prod == 32'd1460) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midflight_ghost got rsp for discarded op want none");
        end
        drive(1, 16'd1, 16'd2, 1, 16'd3, 16'd4);
        step(o, w);
        checks++;
        if (o !== w || !o.r0 || o.r1) begin
            failures++;
            $display("FAIL midflight_rr got r0=%b r1=%b want r0=1 r1=0", o.r0, o.r1);
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(o, w);
    endtask

    task automatic test_streaming();
        obs_t o, w;
        logic [31:0] rp[$];
        int          rc[$];
        logic        bad_id;
        bad_id = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i < 10) drive(0, 0, 0, 1, 16'(i + 1), 16'(i + 2));
            else        drive(0, 0, 0, 0, 0, 0);
            step(o, w);
            checks++;
            if (o !== w) begin
                failures++;
                $display("FAIL stream[%0d] got=%h want=%h", i, o, w);
            end
            if (o.v) begin
                rp.push_back(o.prod);
                rc.push_back(cyc);
                if (o.id !== 1'b1) bad_id = 1'b1;
            end
        end
        checks++;
        if (rp.size() != 10 || bad_id) begin
            failures++;
            $display("FAIL stream_cnt got n=%0d bad_id=%b want n=10 id=1",
                     rp.size(), bad_id);
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (rp[i] != 32'((i + 1) * (i + 2)) || rc[i] != rc[0] + i) begin
                    failures++;
                    $display("FAIL stream_rsp[%0d] got p=%0d want p=%0d",
                             i, rp[i], (i + 1) * (i + 2));
                end
            end
        end
    endtask

    function automatic logic [15:0] pick_op();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random();
        obs_t o, w;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            drive($urandom_range(0, 3) != 0, pick_op(), pick_op(),
                  $urandom_range(0, 3) != 0, pick_op(), pick_op());
            step(o, w);
            checks++;
            if (o !== w) begin
                failures++;
                $display("FAIL random[%0d] got=%h want=%h", i, o, w);
            end
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < LAT + 3; i++) begin
            step(o, w);
            checks++;
            if (o !== w) begin
                failures++;
                $display("FAIL drain[%0d] got=%h want=%h", i, o, w);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_single();
        test_contention();
        test_corners();
        test_reset_midflight();
        test_streaming();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vedicmult_arbiter.md
VEDICMULT_ARBITER -- requirements
Module: vedicmult_arbiter

Interface
REQ-001 SHALL have parameter MULT_LAT, default 1: clock cycles from operands at the vedicmult_16bit inputs to the product at its out.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1: requester k presents an operand pair.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, 16 each: unsigned operands.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1: requester k's pair is accepted this cycle.
REQ-007 SHALL have port rsp_valid, output, 1: a one-cycle pulse marking a completed product.
REQ-008 SHALL have port rsp_id, output, 1: the index of the requester that owns the product.
REQ-009 SHALL have port rsp_prod, output, 32: the unsigned product a*b.
REQ-010 SHALL have port busy, output, 1: at least one accepted operation has not yet produced its response.

Function
REQ-011 SHALL define a transfer as valid_k && ready_k on a rising edge; at most one transfer SHALL occur per cycle.
REQ-012 SHALL drive ready_k = !reset && valid_k && (rr == k || !valid_other); this is a combinational valid-to-ready path.
REQ-013 SHALL set rr <= 1-k after a transfer by requester k and SHALL hold rr when no transfer occurs.
REQ-014 SHALL alternate grants 0,1,0,1... while both requesters hold valid high; no requester SHALL wait more than 1 cycle under contention.
REQ-015 SHALL register the accepted operands into op_a/op_b on the transfer edge T; these registers drive the multiplier's a/b inputs from cycle T+1.
REQ-016 SHALL hold op_a/op_b at their last values in cycles with no transfer, so the multiplier inputs do not toggle.
REQ-017 SHALL track in-flight operations in a shift register of (valid, id) with depth 1+MULT_LAT, shifted every cycle.
REQ-018 SHALL assert rsp_valid in cycle T+1+MULT_LAT with rsp_id = k and rsp_prod = multiplier out; the default latency is 2 cycles.
REQ-019 SHALL sustain a throughput of 1 operation per cycle, with no bubble between back-to-back transfers from either requester.
REQ-020 SHALL return responses in acceptance order; the response path has no backpressure.
REQ-021 SHALL force rsp_prod = 0 and rsp_id = 0 whenever rsp_valid is low.
REQ-022 SHALL drive busy = OR of all shift-register valid bits.
REQ-023 SHALL produce exact products at the operand extremes: 0xFFFF*0xFFFF = 0xFFFE0001, and 0*x = 0.

Reset
REQ-024 SHALL, while reset is high, clear rr to 0, clear all in-flight valid bits, clear op_a/op_b to 0, and drive both readies low.
REQ-025 SHALL make rsp_valid, rsp_id, rsp_prod and busy all 0 in the first cycle after a reset edge.
REQ-026 SHALL discard in-flight operations when reset asserts mid-operation; no response for a discarded operation SHALL ever appear.
REQ-027 SHALL connect the multiplier's reset to the block reset.

Structure
REQ-028 SHALL take W_OP=16, W_PROD=32, MULT_LAT default and the requester-id type from the shared package vedicmult_pkg.
REQ-029 SHALL instantiate exactly one sub-module, vedicmult_16bit, with port order (a, b, clk, reset, out).
REQ-030 SHALL contain the arbiter, operand registers and tracking shift register in this module; no further sub-modules.

Verification
REQ-031 SHALL cover reset: hold reset 3 cycles with both valids high -> readies 0, rsp_valid 0, busy 0 throughout and one cycle after.
REQ-032 SHALL cover a single request: req0 a=5, b=8, accepted at T -> rsp_valid at T+2 with rsp_id=0, rsp_prod=40; busy high over T+1..T+2.
REQ-033 SHALL cover contention: both valid for 4 cycles, req0 25x27 and req1 19x20 -> grants 0,1,0,1; responses 675/id0, 380/id1, 675/id0, 380/id1 on consecutive cycles.
REQ-034 SHALL cover corner operands: 0xFFFF*0xFFFF -> 0xFFFE0001; 0x0000*0x1234 -> 0.
REQ-035 SHALL cover reset mid-flight: accept 73x20 at T, reset at T+1 -> 1460 never appears, rr=0, busy=0.
REQ-036 SHALL cover streaming: req1 alone for 10 consecutive cycles with a=i, b=i+1 -> 10 consecutive responses, id=1, products i*(i+1) in order.
